// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to NUM_CDB completed FUB results per cycle onto a registered CDB.
// Optional starvation guard enabled by defining CDB_STARVE_GUARD_EN.
module cdb_arbiter #(
    parameter int unsigned NUM_FUB = 4,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TAG_W   = 6
`ifdef CDB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_FUB-1:0]          fub_valid,
    input  logic [NUM_FUB*DATA_W-1:0]   fub_result,
    input  logic [NUM_FUB*TAG_W-1:0]    fub_tagDest,
    input  logic                        cdb_flush,
    output logic [NUM_FUB-1:0]          cdb_stall,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_value
);

    localparam int unsigned PTR_W = (NUM_FUB > 1) ? $clog2(NUM_FUB) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_FUB-1:0] granted;
    logic [NUM_CDB-1:0] port_vld;
    logic [PTR_W-1:0]   port_src [NUM_CDB];
    logic [TAG_W-1:0]   tag_arr  [NUM_FUB];
    logic [DATA_W-1:0]  res_arr  [NUM_FUB];

    for (genvar g = 0; g < NUM_FUB; g++) begin : g_unpack
        assign tag_arr[g] = fub_tagDest[g*TAG_W +: TAG_W];
        assign res_arr[g] = fub_result[g*DATA_W +: DATA_W];
    end

    // Circular source index: (base + off) mod NUM_FUB, off < NUM_FUB.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_FUB) begin
            sum = sum - NUM_FUB;
        end
        return PTR_W'(sum);
    endfunction

`ifdef CDB_STARVE_GUARD_EN
    localparam int unsigned WCNT_W = 3;

    logic [WCNT_W-1:0]  wait_cnt [NUM_FUB];
    logic [NUM_FUB-1:0] starved;

    for (genvar g = 0; g < NUM_FUB; g++) begin : g_starved
        assign starved[g] = 32'(wait_cnt[g]) >= STARVE_LIMIT;
    end

    // Saturating wait counters: count stalled cycles, clear on transfer or idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_FUB; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_FUB; i++) begin
                if (!fub_valid[i] || !cdb_stall[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != '1) begin
                    wait_cnt[i] <= wait_cnt[i] + WCNT_W'(1);
                end
            end
        end
    end
`endif

    // Grant selection: starved sources first (if enabled), then circular scan from rr_ptr.
    always_comb begin
        int unsigned      n;
        logic [PTR_W-1:0] idx;
        granted  = '0;
        port_vld = '0;
        rr_next  = rr_ptr;
        n        = 0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            port_src[k] = '0;
        end
`ifdef CDB_STARVE_GUARD_EN
        for (int unsigned i = 0; i < NUM_FUB; i++) begin
            if (fub_valid[i] && starved[i] && n < NUM_CDB) begin
                granted[i] = 1'b1;
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (k == n) begin
                        port_vld[k] = 1'b1;
                        port_src[k] = PTR_W'(i);
                    end
                end
                n = n + 1;
            end
        end
`endif
        for (int unsigned j = 0; j < NUM_FUB; j++) begin
            idx = wrap_idx(rr_ptr, j);
            if (fub_valid[idx] && !granted[idx] && n < NUM_CDB) begin
                granted[idx] = 1'b1;
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (k == n) begin
                        port_vld[k] = 1'b1;
                        port_src[k] = idx;
                    end
                end
                n       = n + 1;
                rr_next = wrap_idx(idx, 1);
            end
        end
    end

    // Flush and reset block every transfer, including from idle sources.
    assign cdb_stall = (reset || cdb_flush) ? '1 : (fub_valid & ~granted);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (!cdb_flush) begin
            rr_ptr <= rr_next;
        end
    end

    // Broadcast registers; idle ports carry zero tag/value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
        end else if (cdb_flush) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb_valid[k]                  <= port_vld[k];
                cdb_tag[k*TAG_W +: TAG_W]     <= port_vld[k] ? tag_arr[port_src[k]] : '0;
                cdb_value[k*DATA_W +: DATA_W] <= port_vld[k] ? res_arr[port_src[k]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (default build): directed scenarios plus randomized traffic vs. a scan model.
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int NC = 2;
    localparam int DW = 64;
    localparam int TW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [NF-1:0]     fub_valid;
    logic [NF*DW-1:0]  fub_result;
    logic [NF*TW-1:0]  fub_tagDest;
    logic              cdb_flush;
    logic [NF-1:0]     cdb_stall;
    logic [NC-1:0]     cdb_valid;
    logic [NC*TW-1:0]  cdb_tag;
    logic [NC*DW-1:0]  cdb_value;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    logic [TW-1:0] src_tag [NF];
    logic [DW-1:0] src_val [NF];

    cdb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .fub_valid   (fub_valid),
        .fub_result  (fub_result),
        .fub_tagDest (fub_tagDest),
        .cdb_flush   (cdb_flush),
        .cdb_stall   (cdb_stall),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value)
    );

    always #5 clk = ~clk;

    task automatic pack_inputs(input logic [NF-1:0] v);
        fub_valid = v;
        for (int i = 0; i < NF; i++) begin
            fub_tagDest[i*TW +: TW] = src_tag[i];
            fub_result[i*DW +: DW]  = src_val[i];
        end
    endtask

    // Reference: visit sources (ptr, ptr+1, ...) mod NF, first NC valid ones win, ptr moves past the last winner.
    task automatic model_cycle(input logic [NF-1:0] v, input logic fl,
                               output logic [NF-1:0] stall_e, output logic [NC-1:0] vld_e,
                               output logic [NC*TW-1:0] tag_e, output logic [NC*DW-1:0] val_e);
        int n;
        int last;
        int s;
        n = 0;
        last = -1;
        stall_e = v;
        vld_e = '0;
        tag_e = '0;
        val_e = '0;
        for (int j = 0; j < NF; j++) begin
            s = (m_ptr + j) % NF;
            if (v[s] && n < NC) begin
                stall_e[s] = 1'b0;
                vld_e[n] = 1'b1;
                tag_e[n*TW +: TW] = src_tag[s];
                val_e[n*DW +: DW] = src_val[s];
                n++;
                last = s;
            end
        end
        if (fl) begin
            stall_e = '1;
            vld_e = '0;
            tag_e = '0;
            val_e = '0;
        end else if (last >= 0) begin
            m_ptr = (last + 1) % NF;
        end
    endtask

    task automatic test_reset();
        logic [NF-1:0] se; logic [NC-1:0] ve; logic [NC*TW-1:0] te; logic [NC*DW-1:0] vae;
        reset = 1'b1;
        cdb_flush = 1'b0;
        for (int i = 0; i < NF; i++) begin
            src_tag[i] = TW'(i + 1);
            src_val[i] = DW'(64'h1000 + i);
        end
        pack_inputs(4'b1111);
        #1;
        total++;
        if (cdb_stall !== 4'b1111) begin
            bad++; $display("FAIL reset_stall: got %b want 1111", cdb_stall);
        end
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++; $display("FAIL reset_valid: got %b want 00", cdb_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        #1;
        model_cycle(fub_valid, 1'b0, se, ve, te, vae);
        total++;
        if (cdb_stall !== 4'b1100) begin
            bad++; $display("FAIL first_grant_stall: got %b want 1100", cdb_stall);
        end
        @(posedge clk);
        #1;
        total++;
        if (cdb_valid !== 2'b11 || cdb_tag !== {src_tag[1], src_tag[0]} ||
            cdb_value !== {src_val[1], src_val[0]}) begin
            bad++; $display("FAIL first_broadcast: got v=%b t=%h want v=11 t=%h",
                            cdb_valid, cdb_tag, {src_tag[1], src_tag[0]});
        end
    endtask

    task automatic test_rotation();
        logic [NF-1:0] se; logic [NC-1:0] ve; logic [NC*TW-1:0] te; logic [NC*DW-1:0] vae;
        logic [NF-1:0] rot_exp [4];
        rot_exp = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NF; i++) begin
                src_tag[i] = TW'(8 * c + i);
                src_val[i] = DW'($urandom);
            end
            pack_inputs(4'b1111);
            #1;
            model_cycle(fub_valid, 1'b0, se, ve, te, vae);
            total++;
            if (cdb_stall !== rot_exp[c]) begin
                bad++; $display("FAIL rotation_stall[%0d]: got %b want %b", c, cdb_stall, rot_exp[c]);
            end
            @(posedge clk);
            #1;
            total++;
            if ({cdb_valid, cdb_tag, cdb_value} !== {ve, te, vae}) begin
                bad++; $display("FAIL rotation_bcast[%0d]: got v=%b t=%h want v=%b t=%h",
                                c, cdb_valid, cdb_tag, ve, te);
            end
        end
    endtask

    task automatic test_single();
        logic [NF-1:0] se; logic [NC-1:0] ve; logic [NC*TW-1:0] te; logic [NC*DW-1:0] vae;
        src_tag[3] = 6'h2A;
        src_val[3] = 64'hDEAD;
        pack_inputs(4'b1000);
        #1;
        model_cycle(fub_valid, 1'b0, se, ve, te, vae);
        total++;
        if (cdb_stall !== 4'b0000) begin
            bad++; $display("FAIL single_stall: got %b want 0000", cdb_stall);
        end
        @(posedge clk);
        #1;
        total++;
        if (cdb_valid !== 2'b01 || cdb_tag !== {6'h00, 6'h2A} ||
            cdb_value !== {64'h0, 64'hDEAD}) begin
            bad++; $display("FAIL single_bcast: got v=%b t=%h val=%h want v=01 t=002a val=dead",
                            cdb_valid, cdb_tag, cdb_value);
        end
    endtask

    task automatic test_flush();
        logic [NF-1:0] se; logic [NC-1:0] ve; logic [NC*TW-1:0] te; logic [NC*DW-1:0] vae;
        pack_inputs(4'b0110);
        cdb_flush = 1'b1;
        #1;
        model_cycle(fub_valid, 1'b1, se, ve, te, vae);
        total++;
        if ((cdb_stall & fub_valid) !== 4'b0110) begin
            bad++; $display("FAIL flush_stall: got %b want valid sources 0110 stalled", cdb_stall);
        end
        @(posedge clk);
        #1;
        cdb_flush = 1'b0;
        total++;
        if (cdb_valid !== 2'b00) begin
            bad++; $display("FAIL flush_valid: got %b want 00", cdb_valid);
        end
        #1;
        model_cycle(fub_valid, 1'b0, se, ve, te, vae);
        total++;
        if (cdb_stall !== 4'b0000) begin
            bad++; $display("FAIL post_flush_stall: got %b want 0000", cdb_stall);
        end
        @(posedge clk);
        #1;
        total++;
        if (cdb_valid !== 2'b11 || cdb_tag !== {src_tag[2], src_tag[1]}) begin
            bad++; $display("FAIL post_flush_bcast: got v=%b t=%h want v=11 t=%h",
                            cdb_valid, cdb_tag, {src_tag[2], src_tag[1]});
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_value !== '0) begin
            bad++; $display("FAIL async_reset_out: got v=%b t=%h before next edge, want all zero",
                            cdb_valid, cdb_tag);
        end
        total++;
        if (cdb_stall !== 4'b1111) begin
            bad++; $display("FAIL async_reset_stall: got %b want 1111", cdb_stall);
        end
        fub_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [NF-1:0] se; logic [NC-1:0] ve; logic [NC*TW-1:0] te; logic [NC*DW-1:0] vae;
        logic [NF-1:0] v;
        logic [NF-1:0] hold;
        logic [NF-1:0] chk;
        logic fl;
        v = '0;
        hold = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int i = 0; i < NF; i++) begin
                if (!hold[i]) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    src_tag[i] = TW'($urandom);
                    src_val[i] = {$urandom, $urandom};
                end
            end
            fl = ($urandom_range(0, 9) == 0);
            cdb_flush = fl;
            pack_inputs(v);
            #1;
            model_cycle(v, fl, se, ve, te, vae);
            chk = fl ? (cdb_stall | ~v) : cdb_stall;
            total++;
            if (chk !== se) begin
                bad++; $display("FAIL rand_stall[%0d]: got %b want %b (valid %b flush %b)",
                                cyc, cdb_stall, se, v, fl);
            end
            hold = v & se;
            @(posedge clk);
            #1;
            total++;
            if ({cdb_valid, cdb_tag, cdb_value} !== {ve, te, vae}) begin
                bad++; $display("FAIL rand_bcast[%0d]: got v=%b t=%h val=%h want v=%b t=%h val=%h",
                                cyc, cdb_valid, cdb_tag, cdb_value, ve, te, vae);
            end
        end
        cdb_flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
